// File: rtl/chess_pkg.sv
// chess_pkg: shared FSM states, board geometry and square indexing for the board scanner.
package chess_pkg;
   localparam int NUM_ROWS = 8;
   localparam int NUM_SQ   = 64;
   typedef logic [5:0] sq_idx_t;
   typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, FRAME_END, EMIT} state_e;
   // Row k occupies bits [63-8k:56-8k], so its lowest bit is 8*(7-k).
   function automatic sq_idx_t row_lsb(input logic [2:0] row);
      return {~row, 3'b000};
   endfunction
endpackage

// File: rtl/lsb_find64.sv
// lsb_find64: lowest-set-bit encoder for a 64-bit vector, plus an any-set flag.
module lsb_find64
   import chess_pkg::*;
(
   input  logic [NUM_SQ-1:0] v,
   output sq_idx_t           idx,
   output logic              any
);
   always_comb begin
      idx = '0;
      for (int i = NUM_SQ - 1; i >= 0; i--) idx = v[i] ? sq_idx_t'(i) : idx;
   end
   assign any = |v;
endmodule

// File: rtl/board_scan_ctrl.sv
// board_scan_ctrl: scans an 8x8 sense matrix row by row, debounces whole frames
// and reports every square change of the accepted board as a valid/ready event.
module board_scan_ctrl
   import chess_pkg::*;
#(
   parameter int ROW_SETTLE      = 4,
   parameter int DEBOUNCE_FRAMES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  c,
   output logic [7:0]  r,
   output logic [63:0] stable_board,
   output logic        frame_done,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [5:0]  ev_square,
   output logic        ev_occupied
);
   localparam logic [7:0] SETTLE_LAST = 8'(ROW_SETTLE - 1);
   localparam logic [3:0] ACCEPT_AT   = 4'(DEBOUNCE_FRAMES - 1);
   localparam logic [2:0] LAST_ROW    = 3'(NUM_ROWS - 1);
   state_e            state_q, state_d;
   logic [2:0]        row_q, row_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        match_q, match_d;
   logic [NUM_SQ-1:0] raw_q, raw_d, prev_q, prev_d, diff_q, diff_d, stable_q, stable_d;
   sq_idx_t           lsb_idx;
   logic              lsb_any;
   lsb_find64 u_lsb (.v(diff_q), .idx(lsb_idx), .any(lsb_any));
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         cnt_q    <= '0;
         match_q  <= '0;
         raw_q    <= '0;
         prev_q   <= '0;
         diff_q   <= '0;
         stable_q <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         match_q  <= match_d;
         raw_q    <= raw_d;
         prev_q   <= prev_d;
         diff_q   <= diff_d;
         stable_q <= stable_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      match_d  = match_q;
      raw_d    = raw_q;
      prev_d   = prev_q;
      diff_d   = diff_q;
      stable_d = stable_q;
      case (state_q)
         IDLE: if (enable) begin
            state_d = DRIVE;
            row_d   = '0;
            cnt_d   = '0;
         end
         DRIVE: if (!enable) begin
            state_d = IDLE;
            match_d = '0;
            raw_d   = '0;
         end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (cnt_q == SETTLE_LAST) ? SAMPLE : DRIVE;
         end
         SAMPLE: if (!enable) begin
            state_d = IDLE;
            match_d = '0;
            raw_d   = '0;
         end else begin
            raw_d[row_lsb(row_q) +: 8] = c;
            row_d   = row_q + 3'd1;
            cnt_d   = '0;
            state_d = (row_q == LAST_ROW) ? FRAME_END : DRIVE;
         end
         FRAME_END: begin
            match_d = (raw_q != prev_q) ? 4'd0 : (match_q == 4'd15) ? match_q : match_q + 4'd1;
            prev_d  = raw_q;
            if (match_d >= ACCEPT_AT && raw_q != stable_q) begin
               state_d = EMIT;
               diff_d  = raw_q ^ stable_q;
            end else begin
               state_d = enable ? DRIVE : IDLE;
               row_d   = '0;
               cnt_d   = '0;
            end
         end
         EMIT: if (ev_ready) begin
            diff_d[lsb_idx]   = 1'b0;
            stable_d[lsb_idx] = raw_q[lsb_idx];
            if (diff_d == '0) begin
               state_d = enable ? DRIVE : IDLE;
               row_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      r            = (state_q == DRIVE || state_q == SAMPLE) ? 8'b1 << row_q : 8'b0;
      frame_done   = state_q == FRAME_END;
      ev_valid     = state_q == EMIT && lsb_any;
      ev_square    = ev_valid ? lsb_idx : '0;
      ev_occupied  = ev_valid && raw_q[lsb_idx];
      stable_board = stable_q;
   end
endmodule

// File: doc/board_scan_ctrl.md
BOARD_SCAN_CTRL -- requirements
Module: board_scan_ctrl

Interface
REQ-001 Parameter ROW_SETTLE, default 4, cycles a row is driven before its columns are sampled (range 1..255).
REQ-002 Parameter DEBOUNCE_FRAMES, default 3, consecutive identical frames required before a frame is accepted (range 1..15).
REQ-003 clk  input  1  single block clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 enable  input  1  scanning permitted while high.
REQ-006 c  input  8  column sense lines for the driven row; 1 = piece present.
REQ-007 r  output  8  row drive, one-hot while scanning, else all zero.
REQ-008 stable_board  output  64  debounced board; row k occupies bits [63-8k:56-8k], column j at bit (63-8k)-(7-j).
REQ-009 frame_done  output  1  one-cycle pulse when a full raw frame has been captured.
REQ-010 ev_valid  output  1  a square-change event is offered.
REQ-011 ev_ready  input  1  consumer accepts the event.
REQ-012 ev_square  output  6  bit index (0..63) of the changed square in stable_board.
REQ-013 ev_occupied  output  1  new value of that square.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE, FRAME_END and EMIT.
REQ-015 IDLE: r = 0; enable high -> DRIVE with row = 0 and settle count = 0.
REQ-016 DRIVE: r = one-hot(row); count increments each cycle; after ROW_SETTLE cycles -> SAMPLE.
REQ-017 SAMPLE: r held; c registered into raw-frame bits of the current row at the end of that one cycle; row < 7 -> DRIVE with row+1, row = 7 -> FRAME_END.
REQ-018 A frame SHALL take exactly 8*(ROW_SETTLE+1) cycles from first DRIVE cycle to FRAME_END entry.
REQ-019 FRAME_END (one cycle, r = 0): frame_done pulses; if raw == previous raw, the match count increments (saturating at 15), else it clears to 0; raw is copied to previous raw.
REQ-020 A frame SHALL be accepted when the updated match count >= DEBOUNCE_FRAMES-1 (DEBOUNCE_FRAMES = 1 accepts every frame).
REQ-021 Accepted frame with raw != stable_board -> EMIT with diff = raw ^ stable_board; otherwise -> DRIVE row 0 (or IDLE if enable is low).
REQ-022 EMIT: r = 0; ev_valid high; ev_square = lowest set diff bit; ev_occupied = raw bit at that index.
REQ-023 ev_square and ev_occupied SHALL stay constant while ev_valid is high and ev_ready is low.
REQ-024 Transfer occurs on a rising edge with ev_valid and ev_ready both high.
- On transfer the diff bit clears and that stable_board bit updates in the same edge.
- The next event is valid on the following cycle (back-to-back, one event per cycle maximum).
REQ-025 When diff becomes zero, ev_valid SHALL drop on the next cycle and the FSM returns to DRIVE row 0 (or IDLE if enable is low).
REQ-026 enable low in DRIVE or SAMPLE SHALL abort to IDLE on the next edge, discard the partial frame and clear the match count.
REQ-027 enable low in EMIT SHALL NOT abort; emission completes first.
REQ-028 stable_board SHALL change only through EMIT transfers.

Reset
REQ-029 While reset = 0: state IDLE; r, stable_board, raw, previous raw and diff are 0; match count 0; frame_done 0; ev_valid 0; ev_square 0; ev_occupied 0.
REQ-030 Reset assertion mid-frame or mid-EMIT SHALL take effect immediately and drop any pending event; the first accepted frame after reset reports every occupied square.

Structure
REQ-031 Shared package chess_pkg SHALL hold the state enum, NUM_ROWS = 8, NUM_SQ = 64, the square-index typedef and the row-to-bit-slice function.
REQ-032 One sub-module, lsb_find64 (combinational lowest-set-bit encoder, 64 -> 6 plus any-set flag), SHALL be used by EMIT.

Verification
REQ-033 Use ROW_SETTLE = 2 and DEBOUNCE_FRAMES = 3 for all scenarios below.
REQ-034 Reset, enable = 1, static empty board -> r steps 0x01, 0x02, ... 0x80, each for 3 cycles; frame_done every 25 cycles; no events.
REQ-035 Piece at row 0 col 7 held for 3 frames, ev_ready = 1 -> single event ev_square = 63, ev_occupied = 1 after the third frame_done; stable_board = 0x8000_0000_0000_0000.
REQ-036 Setup: rows 1 and 7 change simultaneously (bits 48 and 0). Hold ev_ready = 0 for 5 cycles -> square 0 is held stable, then square 48 follows on consecutive cycles.
REQ-037 Bit 10 toggles every frame -> match count never reaches 2; no events; stable_board unchanged.
REQ-038 enable drops during row 4 SAMPLE -> r = 0 next cycle and IDLE; re-enable restarts at row 0 with match count 0. Asserting reset during EMIT -> ev_valid = 0 immediately.
